// File: rtl/projection_histogram.sv
// Row/column projection histogram with peak tracking,
// sticky error flags and back-pressured readout of both axes.
module projection_histogram #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 8,
  parameter int PIX_W  = 1,
  parameter int CNT_W  = 8,
  parameter int MODE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pixelValid,
  input  logic [ADDR_W-1:0] xAddress,
  input  logic [ADDR_W-1:0] yAddress,
  input  logic [PIX_W-1:0]  pixelData,
  input  logic [PIX_W-1:0]  threshold,
  input  logic              frameDone,
  input  logic              readHistogram,
  input  logic              outReady,
  output logic [CNT_W-1:0]  histogramOut,
  output logic [ADDR_W-1:0] histogramIndex,
  output logic              xValid,
  output logic              yValid,
  output logic              busy,
  output logic              histogramDone,
  output logic [ADDR_W-1:0] peakX,
  output logic [ADDR_W-1:0] peakY,
  output logic              overflow,
  output logic              addrError
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ADDR_W:0] X_LIM = (ADDR_W+1)'(IMG_W);
  localparam logic [ADDR_W:0] Y_LIM = (ADDR_W+1)'(IMG_H);
  localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [2:0] {
    IDLE, ACCUM, DRAIN, READ_X, READ_Y
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0] xbin [IMG_W];
  logic [CNT_W-1:0] ybin [IMG_H];

  logic              s1_hit;
  logic [ADDR_W-1:0] s1_x, s1_y;
  logic              drain_cnt;
  logic [CNT_W-1:0]  pk_cnt_x, pk_cnt_y;
  logic              fg, ge, in_range;
  logic              x_sat, y_sat;
  logic [CNT_W-1:0]  xv, yv, xv_nx, yv_nx;
  logic [ADDR_W-1:0] idx_nx;

  assign busy = (state != IDLE);

  // Foreground classification of the incoming pixel
  always_comb begin
    ge = (pixelData >= threshold);
    fg = (MODE == 0) ? pixelData[0] : ge;
  end

  // Read side of the bin read-modify-write, with saturation
  always_comb begin
    in_range = ({1'b0, s1_x} < X_LIM) && ({1'b0, s1_y} < Y_LIM);
    xv = '0;
    yv = '0;
    if (in_range) begin
      xv = xbin[s1_x[XW-1:0]];
      yv = ybin[s1_y[YW-1:0]];
    end
    x_sat  = (xv == CMAX);
    y_sat  = (yv == CMAX);
    xv_nx  = x_sat ? xv : xv + 1'b1;
    yv_nx  = y_sat ? yv : yv + 1'b1;
    idx_nx = histogramIndex + 1'b1;
  end

  // Next-state logic; start overrides everything
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (readHistogram) state_nx = READ_X;
      ACCUM:  if (frameDone) state_nx = DRAIN;
      DRAIN:  if (drain_cnt) state_nx = IDLE;
      READ_X: if (outReady && histogramIndex == X_LAST)
                state_nx = READ_Y;
      READ_Y: if (outReady && histogramIndex == Y_LAST)
                state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (start) state_nx = ACCUM;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Capture stage: qualify hits only while accumulating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_hit <= 1'b0;
      s1_x   <= '0;
      s1_y   <= '0;
    end else begin
      s1_hit <= !start && (state == ACCUM) && pixelValid && fg;
      s1_x   <= xAddress;
      s1_y   <= yAddress;
    end
  end

  // Bin update, peak tracking and sticky flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < IMG_W; i++) xbin[i] <= '0;
      for (int i = 0; i < IMG_H; i++) ybin[i] <= '0;
      pk_cnt_x  <= '0;
      pk_cnt_y  <= '0;
      peakX     <= '0;
      peakY     <= '0;
      overflow  <= 1'b0;
      addrError <= 1'b0;
    end else if (start) begin
      for (int i = 0; i < IMG_W; i++) xbin[i] <= '0;
      for (int i = 0; i < IMG_H; i++) ybin[i] <= '0;
      pk_cnt_x  <= '0;
      pk_cnt_y  <= '0;
      peakX     <= '0;
      peakY     <= '0;
      overflow  <= 1'b0;
      addrError <= 1'b0;
    end else if (s1_hit) begin
      if (!in_range) begin
        addrError <= 1'b1;
      end else begin
        xbin[s1_x[XW-1:0]] <= xv_nx;
        ybin[s1_y[YW-1:0]] <= yv_nx;
        if (x_sat || y_sat) overflow <= 1'b1;
        if (xv_nx > pk_cnt_x ||
            (xv_nx == pk_cnt_x && s1_x < peakX)) begin
          pk_cnt_x <= xv_nx;
          peakX    <= s1_x;
        end
        if (yv_nx > pk_cnt_y ||
            (yv_nx == pk_cnt_y && s1_y < peakY)) begin
          pk_cnt_y <= yv_nx;
          peakY    <= s1_y;
        end
      end
    end
  end

  // Two-cycle drain timer and completion pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drain_cnt     <= 1'b0;
      histogramDone <= 1'b0;
    end else begin
      drain_cnt     <= !start && (state == DRAIN) && !drain_cnt;
      histogramDone <= !start && (state == DRAIN) && drain_cnt;
    end
  end

  // Readout: present bin at index, advance on each transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xValid         <= 1'b0;
      yValid         <= 1'b0;
      histogramOut   <= '0;
      histogramIndex <= '0;
    end else if (start) begin
      xValid         <= 1'b0;
      yValid         <= 1'b0;
      histogramOut   <= '0;
      histogramIndex <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE && readHistogram): begin
          xValid         <= 1'b1;
          histogramIndex <= '0;
          histogramOut   <= xbin[0];
        end
        (state == READ_X && outReady): begin
          if (histogramIndex == X_LAST) begin
            xValid         <= 1'b0;
            yValid         <= 1'b1;
            histogramIndex <= '0;
            histogramOut   <= ybin[0];
          end else begin
            histogramIndex <= idx_nx;
            histogramOut   <= xbin[idx_nx[XW-1:0]];
          end
        end
        (state == READ_Y && outReady): begin
          if (histogramIndex == Y_LAST) begin
            yValid <= 1'b0;
          end else begin
            histogramIndex <= idx_nx;
            histogramOut   <= ybin[idx_nx[YW-1:0]];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
